// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: sequences sample -> physics -> draw once per refresh tick,
// counting dropped ticks and aborting frames whose physics or draw stalls.
module frame_update_scheduler #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FRAME_W = 16,
   parameter int OVR_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               refreshRate,
   input  logic               pause,
   output logic               sampleEn,
   output logic               physStart,
   input  logic               physDone,
   output logic               drawReq,
   input  logic               drawAck,
   output logic               busy,
   output logic [FRAME_W-1:0] frameCount,
   output logic [OVR_W-1:0]   overrunCount,
   output logic               timeoutErr
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, SAMPLE, PHYS_START, PHYS_WAIT, DRAW, FINISH} state_t;
   state_t state, state_nxt;
   logic abort, wd_hit;
   logic [WD_W-1:0] wd;
   always_comb begin
      state_nxt = state;
      abort = 1'b0;
      wd_hit = wd == WD_W'(TIMEOUT_CYCLES - 1);
      case (state)
         IDLE:       state_nxt = (refreshRate && !pause) ? SAMPLE : IDLE;
         SAMPLE:     state_nxt = PHYS_START;
         PHYS_START: state_nxt = PHYS_WAIT;
         PHYS_WAIT: begin
            abort = !physDone && wd_hit;
            state_nxt = physDone ? DRAW : (wd_hit ? IDLE : PHYS_WAIT);
         end
         DRAW: begin
            abort = !drawAck && wd_hit;
            state_nxt = drawAck ? FINISH : (wd_hit ? IDLE : DRAW);
         end
         default:    state_nxt = IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the state itself
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         sampleEn <= 1'b0;
         physStart <= 1'b0;
         drawReq <= 1'b0;
         busy <= 1'b0;
         frameCount <= '0;
         overrunCount <= '0;
         timeoutErr <= 1'b0;
         wd <= '0;
      end else begin
         state <= state_nxt;
         sampleEn <= state_nxt == SAMPLE;
         physStart <= state_nxt == PHYS_START;
         drawReq <= state_nxt == DRAW;
         busy <= state_nxt != IDLE;
         wd <= (state_nxt != state) ? '0 : wd + WD_W'(1);
         if (state == FINISH)
            frameCount <= frameCount + FRAME_W'(1);
         if (refreshRate && state != IDLE && overrunCount != '1)
            overrunCount <= overrunCount + OVR_W'(1);
         if (abort)
            timeoutErr <= 1'b1;
      end
   end
endmodule
